// File: rtl/wb_commit_queue.sv
//==============================================================================
// Module   : wb_commit_queue
// Brief    : In-order writeback commit queue between MEM and RF/CSR, with
//            rf_ready back-pressure, exception/flush discard and optional
//            result forwarding (enabled by defining WB_FORWARD_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              W_allowin,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_vaddr,
    input  logic              in_gr_we,
    input  logic [4:0]        in_dest,
    input  logic              in_ex,
    input  logic [7:0]        in_ecode,
    input  logic              in_esubcode,
    input  logic              in_csr_we,
    input  logic [13:0]       in_csr_addr,
    input  logic [DATA_W-1:0] in_csr_wmask,
    input  logic [DATA_W-1:0] in_csr_wdata,
    input  logic              ex_en,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              csr_ex,
    output logic [7:0]        csr_ecode,
    output logic              csr_esubcode,
    output logic              csr_we,
    output logic [13:0]       csr_addr,
    output logic [DATA_W-1:0] csr_wmask,
    output logic [DATA_W-1:0] csr_wdata,
    output logic [DATA_W-1:0] csr_pc,
    output logic [DATA_W-1:0] csr_vaddr,
    input  logic [4:0]        fwd_raddr0,
    input  logic [4:0]        fwd_raddr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data0,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;

    logic [DATA_W-1:0] r_pc       [DEPTH];
    logic [DATA_W-1:0] r_result   [DEPTH];
    logic [DATA_W-1:0] r_vaddr    [DEPTH];
    logic              r_gr_we    [DEPTH];
    logic [4:0]        r_dest     [DEPTH];
    logic              r_ex       [DEPTH];
    logic [7:0]        r_ecode    [DEPTH];
    logic              r_esubcode [DEPTH];
    logic              r_csr_we   [DEPTH];
    logic [13:0]       r_csr_addr [DEPTH];
    logic [DATA_W-1:0] r_csr_wmask[DEPTH];
    logic [DATA_W-1:0] r_csr_wdata[DEPTH];

    logic w_nonempty;
    logic w_head_gr;
    logic w_commit;
    logic w_flush_commit;
    logic w_push;

    assign w_nonempty     = (r_count != '0);
    assign w_head_gr      = r_gr_we[r_head] & ~r_ex[r_head];
    // Exception heads never touch the RF, so they commit regardless of rf_ready.
    assign w_commit       = w_nonempty & (~w_head_gr | rf_ready);
    assign w_flush_commit = w_commit & r_ex[r_head];
    assign W_allowin      = (r_count < c_DEPTH_CNT);
    assign w_push         = in_valid & W_allowin & ~ex_en & ~w_flush_commit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (ex_en || w_flush_commit) begin
            r_head  <= r_tail;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_commit) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            case ({w_push, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by count/valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]        <= in_pc;
            r_result[r_tail]    <= in_result;
            r_vaddr[r_tail]     <= in_vaddr;
            r_gr_we[r_tail]     <= in_gr_we;
            r_dest[r_tail]      <= in_dest;
            r_ex[r_tail]        <= in_ex;
            r_ecode[r_tail]     <= in_ecode;
            r_esubcode[r_tail]  <= in_esubcode;
            r_csr_we[r_tail]    <= in_csr_we;
            r_csr_addr[r_tail]  <= in_csr_addr;
            r_csr_wmask[r_tail] <= in_csr_wmask;
            r_csr_wdata[r_tail] <= in_csr_wdata;
        end
    end

    assign rf_we        = w_commit & w_head_gr;
    assign csr_ex       = w_commit & r_ex[r_head];
    assign csr_we       = w_commit & r_csr_we[r_head] & ~r_ex[r_head];
    assign rf_waddr     = w_nonempty ? r_dest[r_head]      : '0;
    assign rf_wdata     = w_nonempty ? r_result[r_head]    : '0;
    assign csr_ecode    = w_nonempty ? r_ecode[r_head]     : '0;
    assign csr_esubcode = w_nonempty ? r_esubcode[r_head]  : 1'b0;
    assign csr_addr     = w_nonempty ? r_csr_addr[r_head]  : '0;
    assign csr_wmask    = w_nonempty ? r_csr_wmask[r_head] : '0;
    assign csr_wdata    = w_nonempty ? r_csr_wdata[r_head] : '0;
    assign csr_pc       = w_nonempty ? r_pc[r_head]        : '0;
    assign csr_vaddr    = w_nonempty ? r_vaddr[r_head]     : '0;

    assign debug_wb_pc       = 32'(csr_pc);
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = 32'(rf_wdata);

`ifdef WB_FORWARD_EN
    logic [c_PTR_W-1:0] w_fwd_idx;

    // Walk from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        w_fwd_idx = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_head + c_PTR_W'(k);
            if (r_valid[w_fwd_idx] && r_gr_we[w_fwd_idx] && !r_ex[w_fwd_idx]) begin
                if ((fwd_raddr0 != 5'd0) && (r_dest[w_fwd_idx] == fwd_raddr0)) begin
                    fwd_hit0  = 1'b1;
                    fwd_data0 = r_result[w_fwd_idx];
                end
                if ((fwd_raddr1 != 5'd0) && (r_dest[w_fwd_idx] == fwd_raddr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = r_result[w_fwd_idx];
                end
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_raddr0, fwd_raddr1, r_valid};
    assign fwd_hit0     = 1'b0;
    assign fwd_hit1     = 1'b0;
    assign fwd_data0    = '0;
    assign fwd_data1    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
//==============================================================================
// Module   : tb_wb_commit_queue
// Brief    : Self-checking bench for wb_commit_queue (DEPTH=4, DATA_W=32).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_commit_queue;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        W_allowin;
    logic [31:0] in_pc, in_result, in_vaddr;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic        in_ex;
    logic [7:0]  in_ecode;
    logic        in_esubcode;
    logic        in_csr_we;
    logic [13:0] in_csr_addr;
    logic [31:0] in_csr_wmask, in_csr_wdata;
    logic        ex_en;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_ex;
    logic [7:0]  csr_ecode;
    logic        csr_esubcode;
    logic        csr_we;
    logic [13:0] csr_addr;
    logic [31:0] csr_wmask, csr_wdata, csr_pc, csr_vaddr;
    logic [4:0]  fwd_raddr0, fwd_raddr1;
    logic        fwd_hit0, fwd_hit1;
    logic [31:0] fwd_data0, fwd_data1;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_commit_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .W_allowin(W_allowin),
        .in_pc(in_pc), .in_result(in_result), .in_vaddr(in_vaddr),
        .in_gr_we(in_gr_we), .in_dest(in_dest),
        .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr),
        .in_csr_wmask(in_csr_wmask), .in_csr_wdata(in_csr_wdata),
        .ex_en(ex_en), .rf_ready(rf_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_ex(csr_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wmask(csr_wmask),
        .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_vaddr(csr_vaddr),
        .fwd_raddr0(fwd_raddr0), .fwd_raddr1(fwd_raddr1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        gwe;
        logic        ex;
        logic [7:0]  ecode;
        logic        cwe;
        logic        rr;
        logic        exen;
        logic        e_allow;
        logic        e_rfwe;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
        logic        e_csrex;
        logic [7:0]  e_ecode;
        logic        e_cwe;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] dest,
        input logic [31:0] res, input logic gwe, input logic ex,
        input logic [7:0] ecode, input logic cwe, input logic rr, input logic exen,
        input logic e_allow, input logic e_rfwe, input logic [4:0] e_waddr,
        input logic [31:0] e_wdata, input logic [31:0] e_pc, input logic e_csrex,
        input logic [7:0] e_ecode, input logic e_cwe);
        vec_t t;
        t.v = v; t.pc = pc; t.dest = dest; t.res = res; t.gwe = gwe; t.ex = ex;
        t.ecode = ecode; t.cwe = cwe; t.rr = rr; t.exen = exen;
        t.e_allow = e_allow; t.e_rfwe = e_rfwe; t.e_waddr = e_waddr;
        t.e_wdata = e_wdata; t.e_pc = e_pc; t.e_csrex = e_csrex;
        t.e_ecode = e_ecode; t.e_cwe = e_cwe;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                         input logic [31:0] res, input logic gwe, input logic ex,
                         input logic [7:0] ecode, input logic cwe);
        in_valid     = v;
        in_pc        = pc;
        in_dest      = dest;
        in_result    = res;
        in_gr_we     = gwe;
        in_ex        = ex;
        in_ecode     = ecode;
        in_csr_we    = cwe;
        in_vaddr     = pc ^ 32'h0000_ff00;
        in_csr_addr  = 14'h0005;
        in_csr_wmask = 32'hffff_ffff;
        in_csr_wdata = res;
        in_esubcode  = 1'b0;
    endtask

    localparam logic [31:0] PA = 32'h1c00_0000;

    logic [31:0] exp_pc[$];
    logic [31:0] exp_res[$];

    initial begin
        rstn = 1'b0; ex_en = 1'b0; rf_ready = 1'b0;
        fwd_raddr0 = 5'd0; fwd_raddr1 = 5'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Basic commit
        tbl.push_back(mk(1, PA, 5, 32'hdeadbeef, 1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 5, 32'hdeadbeef, PA, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        // Back-pressure: fill to DEPTH, fifth held, then drain in order
        tbl.push_back(mk(1, 32'h1c000104, 1, 32'h101, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000108, 2, 32'h102, 1, 0, 0, 0, 0, 0,  1, 0, 1, 32'h101, 32'h1c000104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c00010c, 3, 32'h103, 1, 0, 0, 0, 0, 0,  1, 0, 1, 32'h101, 32'h1c000104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000110, 4, 32'h104, 1, 0, 0, 0, 0, 0,  1, 0, 1, 32'h101, 32'h1c000104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000114, 5, 32'h105, 1, 0, 0, 0, 0, 0,  0, 0, 1, 32'h101, 32'h1c000104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000114, 5, 32'h105, 1, 0, 0, 0, 1, 0,  0, 1, 1, 32'h101, 32'h1c000104, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000114, 5, 32'h105, 1, 0, 0, 0, 1, 0,  1, 1, 2, 32'h102, 32'h1c000108, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 3, 32'h103, 32'h1c00010c, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 4, 32'h104, 32'h1c000110, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 5, 32'h105, 32'h1c000114, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        // Exception commit discards younger work, including a same-cycle enqueue
        tbl.push_back(mk(1, 32'h200, 3, 32'hA, 1, 0, 0,     1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h204, 4, 32'hB, 1, 1, 8'h0b, 1, 0, 0,  1, 0, 3, 32'hA, 32'h200, 0, 0, 0));
        tbl.push_back(mk(1, 32'h208, 6, 32'hC, 1, 0, 0,     0, 0, 0,  1, 0, 3, 32'hA, 32'h200, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 3, 32'hA, 32'h200, 0, 0, 1));
        tbl.push_back(mk(1, 32'h20c, 9, 32'hD, 1, 0, 0, 0, 0, 0,  1, 0, 4, 32'hB, 32'h204, 1, 8'h0b, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        // ex_en flush: head still commits, queue and incoming entry dropped
        tbl.push_back(mk(1, 32'h300, 10, 32'hE1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h304, 11, 32'hE2, 1, 0, 0, 0, 0, 0,  1, 0, 10, 32'hE1, 32'h300, 0, 0, 0));
        tbl.push_back(mk(1, 32'h308, 12, 32'hE3, 1, 0, 0, 0, 0, 0,  1, 0, 10, 32'hE1, 32'h300, 0, 0, 0));
        tbl.push_back(mk(1, 32'h30c, 13, 32'hE4, 1, 0, 0, 0, 1, 1,  1, 1, 10, 32'hE1, 32'h300, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        #2;
        chk("reset W_allowin", 32'(W_allowin), 32'd1);
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset csr_ex", 32'(csr_ex), 32'd0);
        chk("reset debug_wb_pc", debug_wb_pc, 32'd0);
        chk("reset debug_wb_rf_we", 32'(debug_wb_rf_we), 32'd0);
        chk("reset fwd_hit0", 32'(fwd_hit0), 32'd0);
        #6 rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].pc, tbl[i].dest, tbl[i].res, tbl[i].gwe,
                  tbl[i].ex, tbl[i].ecode, tbl[i].cwe);
            rf_ready = tbl[i].rr;
            ex_en    = tbl[i].exen;
            #1;
            chk($sformatf("v%0d W_allowin", i), 32'(W_allowin), 32'(tbl[i].e_allow));
            chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tbl[i].e_rfwe));
            chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d debug_wb_pc", i), debug_wb_pc, tbl[i].e_pc);
            chk($sformatf("v%0d csr_ex", i), 32'(csr_ex), 32'(tbl[i].e_csrex));
            chk($sformatf("v%0d csr_ecode", i), 32'(csr_ecode), 32'(tbl[i].e_ecode));
            chk($sformatf("v%0d csr_we", i), 32'(csr_we), 32'(tbl[i].e_cwe));
            chk($sformatf("v%0d debug_wb_rf_we", i), 32'(debug_wb_rf_we),
                32'({4{tbl[i].e_rfwe}}));
        end

        // Forwarding: two entries to r7, youngest result must win
        @(negedge clk);
        ex_en = 1'b0; rf_ready = 1'b0;
        drive(1, 32'h400, 7, 32'd1, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'h404, 7, 32'd2, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        fwd_raddr0 = 5'd7; fwd_raddr1 = 5'd0;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd hit0", 32'(fwd_hit0), 32'd1);
        chk("fwd data0", fwd_data0, 32'd2);
`else
        chk("fwd hit0", 32'(fwd_hit0), 32'd0);
        chk("fwd data0", fwd_data0, 32'd0);
`endif
        chk("fwd hit1", 32'(fwd_hit1), 32'd0);
        chk("fwd stalled rf_we", 32'(rf_we), 32'd0);
        chk("fwd stalled wnum", 32'(debug_wb_rf_wnum), 32'd7);
        ex_en = 1'b1;
        @(negedge clk);
        ex_en = 1'b0; fwd_raddr0 = 5'd0;
        rf_ready = 1'b1;
        #1;
        chk("post-flush rf_we", 32'(rf_we), 32'd0);
        chk("post-flush wnum", 32'(debug_wb_rf_wnum), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        rf_ready = 1'b0;
        drive(1, 32'h500, 8, 32'h55, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3 rstn = 1'b0;
        #1;
        chk("async rst debug_wb_pc", debug_wb_pc, 32'd0);
        chk("async rst wnum", 32'(debug_wb_rf_wnum), 32'd0);
        chk("async rst W_allowin", 32'(W_allowin), 32'd1);
        @(negedge clk);
        rstn = 1'b1; rf_ready = 1'b1;
        #1;
        chk("after rst rf_we", 32'(rf_we), 32'd0);

        // Stream 3*DEPTH entries with random rf_ready across the pointer wrap
        begin
            int sent = 0;
            int got  = 0;
            for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
                @(negedge clk);
                if (sent < 12)
                    drive(1, 32'h1c001000 + 32'(sent) * 4, 5'((sent % 31) + 1),
                          32'h3000 + 32'(sent) * 32'h11, 1, 0, 0, 0);
                else
                    drive(0, 0, 0, 0, 0, 0, 0, 0);
                rf_ready = 1'($urandom_range(0, 1));
                #1;
                if (rf_we) begin
                    if (exp_pc.size() == 0) begin
                        chk("stream unexpected commit", debug_wb_pc, 32'hffff_ffff);
                    end else begin
                        chk($sformatf("stream pc %0d", got), debug_wb_pc, exp_pc.pop_front());
                        chk($sformatf("stream data %0d", got), rf_wdata, exp_res.pop_front());
                    end
                    got++;
                end
                if (in_valid && W_allowin) begin
                    exp_pc.push_back(in_pc);
                    exp_res.push_back(in_result);
                    sent++;
                end
            end
            chk("stream commit count", 32'(got), 32'd12);
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
